// File: rtl/ex_seq_pkg.sv
// Shared types and constants for the Execute-stage sequencer.
// Default data widths when the data_defs macros are not supplied by the build.
`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 16
`endif
`ifndef IMMEDIATE_WIDTH
`define IMMEDIATE_WIDTH 8
`endif

package ex_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_CAPT = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_t;

    localparam int CTRL_WD      = 7;
    localparam int CTRL_MEM_RD  = 6;
    localparam int CTRL_MEM_WR  = 5;
    localparam int CTRL_ALU_MSB = 4;
    localparam int CTRL_ALU_LSB = 0;

    localparam int MEM_TIMEOUT_DEF = 15;

    // A control word asking for both a load and a store has no meaning.
    function automatic logic ctrl_illegal(input logic [CTRL_WD-1:0] ctrl);
        return ctrl[CTRL_MEM_RD] & ctrl[CTRL_MEM_WR];
    endfunction

    function automatic logic ctrl_is_mem(input logic [CTRL_WD-1:0] ctrl);
        return ctrl[CTRL_MEM_RD] | ctrl[CTRL_MEM_WR];
    endfunction

endpackage

// File: rtl/ex_seq_mem_timer.sv
// Wait-state counter for a data-memory access; timeout is raised during the
// LIMIT-th consecutive cycle without completion.
module ex_seq_mem_timer #(
    parameter int LIMIT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !timeout) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/ex_sequencer.sv
// Single-issue Execute-stage sequencer: issue handshake, one-cycle Execute
// enable, optional data-memory access with timeout, writeback handshake.
module ex_sequencer
    import ex_seq_pkg::*;
#(
    parameter int REG_WD      = `REGISTER_WIDTH,
    parameter int IMM_WD      = `IMMEDIATE_WIDTH,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [6:0]        issue_ctrl,
    input  logic [REG_WD-1:0] issue_src1,
    input  logic [REG_WD-1:0] issue_src2,
    input  logic [IMM_WD-1:0] issue_imm,
    output logic              enable_ex,
    output logic [REG_WD-1:0] ex_src1,
    output logic [REG_WD-1:0] ex_src2,
    output logic [REG_WD-1:0] ex_imm,
    output logic [6:0]        ex_control,
    input  logic [REG_WD-1:0] aluout,
    input  logic              carry,
    output logic              mem_req,
    output logic              mem_we,
    output logic [REG_WD-1:0] mem_addr,
    output logic [REG_WD-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [REG_WD-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_WD-1:0] wb_data,
    output logic              wb_carry,
    output logic              wb_error,
    output logic [15:0]       instr_count,
    output logic [2:0]        state_dbg
);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; valid-side payload is held stable until then.

    state_t              state;
    logic [6:0]          ctrl_q;
    logic [REG_WD-1:0]   src1_q;
    logic [REG_WD-1:0]   src2_q;
    logic [REG_WD-1:0]   imm_q;
    logic                timer_clear;
    logic                timer_enable;
    logic                timeout;

    assign ex_src1    = src1_q;
    assign ex_src2    = src2_q;
    assign ex_imm     = imm_q;
    assign ex_control = ctrl_q;
    assign mem_wdata  = src2_q;
    assign state_dbg  = state;

    assign timer_clear  = (state == S_CAPT);
    assign timer_enable = (state == S_MEM) && !mem_ack;

    ex_seq_mem_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .timeout(timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            ctrl_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            issue_ready <= 1'b1;
            enable_ex   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_carry    <= 1'b0;
            wb_error    <= 1'b0;
            instr_count <= '0;
        end else if (flush && state != S_IDLE) begin
            // Abort: drop everything in flight without retiring it.
            state       <= S_IDLE;
            issue_ready <= 1'b1;
            enable_ex   <= 1'b0;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_carry    <= 1'b0;
            wb_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue_valid && !flush) begin
                        ctrl_q      <= issue_ctrl;
                        src1_q      <= issue_src1;
                        src2_q      <= issue_src2;
                        imm_q       <= REG_WD'($signed(issue_imm));
                        issue_ready <= 1'b0;
                        if (ctrl_illegal(issue_ctrl)) begin
                            state    <= S_WB;
                            wb_valid <= 1'b1;
                            wb_error <= 1'b1;
                            wb_data  <= '0;
                            wb_carry <= 1'b0;
                        end else begin
                            state     <= S_EXEC;
                            enable_ex <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    enable_ex <= 1'b0;
                    state     <= S_CAPT;
                end
                S_CAPT: begin
                    mem_addr <= aluout;
                    wb_carry <= carry;
                    if (ctrl_is_mem(ctrl_q)) begin
                        state   <= S_MEM;
                        mem_req <= 1'b1;
                        mem_we  <= ctrl_q[CTRL_MEM_WR];
                    end else begin
                        state    <= S_WB;
                        wb_valid <= 1'b1;
                        wb_data  <= aluout;
                    end
                end
                S_MEM: begin
                    // An ack in the timeout cycle still completes the access.
                    if (mem_ack) begin
                        state    <= S_WB;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= mem_we ? mem_addr : mem_rdata;
                    end else if (timeout) begin
                        state    <= S_WB;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_error <= 1'b1;
                        wb_data  <= '0;
                    end
                end
                S_WB: begin
                    if (wb_ready) begin
                        state       <= S_IDLE;
                        issue_ready <= 1'b1;
                        wb_valid    <= 1'b0;
                        wb_data     <= '0;
                        wb_carry    <= 1'b0;
                        wb_error    <= 1'b0;
                        instr_count <= instr_count + 16'd1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_sequencer.sv
// Bench for ex_sequencer: per-instruction timeline model, Execute/memory stubs,
// per-cycle comparison, plus literal checks on the directed scenarios.
`timescale 1ns/1ps
module tb_ex_sequencer;
  localparam int RW = 16;
  localparam int IW = 8;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [6:0]    issue_ctrl = '0;
  logic [RW-1:0] issue_src1 = '0;
  logic [RW-1:0] issue_src2 = '0;
  logic [IW-1:0] issue_imm = '0;
  logic          enable_ex;
  logic [RW-1:0] ex_src1, ex_src2, ex_imm;
  logic [6:0]    ex_control;
  logic [RW-1:0] aluout = '0;
  logic          carry = 1'b0;
  logic          mem_req, mem_we;
  logic [RW-1:0] mem_addr, mem_wdata;
  logic          mem_ack = 1'b0;
  logic [RW-1:0] mem_rdata = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [RW-1:0] wb_data;
  logic          wb_carry, wb_error;
  logic [15:0]   instr_count;
  logic [2:0]    state_dbg;

  ex_sequencer #(.REG_WD(RW), .IMM_WD(IW), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_ctrl(issue_ctrl),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_imm(issue_imm),
    .enable_ex(enable_ex), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm),
    .ex_control(ex_control), .aluout(aluout), .carry(carry),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_carry(wb_carry),
    .wb_error(wb_error), .instr_count(instr_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // model of the instruction in flight; k = cycles since the issue handshake
  bit            checking = 0;
  bit            active = 0;
  int            k = 0;
  logic [6:0]    m_ctrl;
  logic [RW-1:0] m_s1, m_s2, m_imm, m_alu, m_data;
  logic          m_carry, m_err, m_legal, m_mem, m_store, m_acked;
  int            m_len = 0;
  int            wb_start = 0;
  logic [15:0]   exp_count = '0;

  // Execute / memory stubs
  logic [RW-1:0] stub_alu = '0;
  logic [RW-1:0] stub_rdata = '0;
  logic          stub_carry = 1'b0;
  int            stub_ack_wait = -1;
  int            req_n = 0;
  bit            prev_en = 0;

  // per-instruction observations
  int            en_cycles, req_cycles, wbv_first;
  logic [RW-1:0] obs_data;
  logic          obs_err;

  bit e_en, e_req, e_wbv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  // aluout/carry are only meaningful the cycle after enable_ex; junk otherwise
  always @(negedge clock) begin
    if (mem_req === 1'b1) begin
      req_n++;
      mem_ack = (stub_ack_wait >= 0) && (req_n == stub_ack_wait + 1);
    end else begin
      req_n = 0;
      mem_ack = ($urandom_range(0, 3) == 0);
    end
    mem_rdata = (mem_req === 1'b1 && mem_ack) ? stub_rdata : RW'($urandom);
    aluout = prev_en ? stub_alu : RW'($urandom);
    carry = prev_en ? stub_carry : 1'($urandom_range(0, 1));
    prev_en = (enable_ex === 1'b1);
  end

  always @(negedge clock) begin
    if (checking) begin
      e_en  = active && m_legal && k == 1;
      e_req = active && m_mem && k >= 3 && k < 3 + m_len;
      e_wbv = active && k >= wb_start;
      check("issue_ready", issue_ready, !active);
      check("enable_ex", enable_ex, e_en);
      check("mem_req", mem_req, e_req);
      check("wb_valid", wb_valid, e_wbv);
      check("instr_count", instr_count, exp_count);
      if (active && m_legal && (k == 1 || k == 2)) begin
        check("ex_src1", ex_src1, m_s1);
        check("ex_src2", ex_src2, m_s2);
        check("ex_imm", ex_imm, m_imm);
        check("ex_control", ex_control, m_ctrl);
      end
      if (e_req) begin
        check("mem_we", mem_we, m_store);
        check("mem_addr", mem_addr, m_alu);
        check("mem_wdata", mem_wdata, m_s2);
      end
      if (e_wbv) begin
        check("wb_data", wb_data, m_data);
        check("wb_carry", wb_carry, m_carry);
        check("wb_error", wb_error, m_err);
      end else begin
        check("wb_data_idle", wb_data, 0);
        check("wb_error_idle", wb_error, 0);
      end
      if (!active) check("wb_carry_idle", wb_carry, 0);
    end
  end

  // ack_wait: wait cycles before ack (<0 = never); flush_at: cycle k to abort (<0 = never)
  task automatic run_instr(input logic [6:0] c, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                           input logic [IW-1:0] im, input logic [RW-1:0] alu, input logic cy,
                           input int ack_wait, input logic [RW-1:0] rd, input int wb_hold,
                           input int flush_at, input bit by_reset);
    bit kill;
    m_ctrl  = c;
    m_s1    = s1;
    m_s2    = s2;
    m_imm   = {{(RW-IW){im[IW-1]}}, im};
    m_alu   = alu;
    m_legal = !(c[6] && c[5]);
    m_mem   = m_legal && (c[6] || c[5]);
    m_store = c[5];
    m_acked = (ack_wait >= 0) && (ack_wait + 1 <= TO);
    m_len   = m_acked ? ack_wait + 1 : TO;
    wb_start = !m_legal ? 1 : (m_mem ? 3 + m_len : 3);
    m_err   = !m_legal || (m_mem && !m_acked);
    if (!m_legal) m_data = '0;
    else if (!m_mem) m_data = alu;
    else if (!m_acked) m_data = '0;
    else m_data = m_store ? alu : rd;
    m_carry = m_legal ? cy : 1'b0;
    stub_alu = alu;
    stub_carry = cy;
    stub_rdata = rd;
    stub_ack_wait = ack_wait;
    en_cycles = 0;
    req_cycles = 0;
    wbv_first = -1;
    obs_data = '0;
    obs_err = 1'b0;

    @(negedge clock);
    issue_ctrl = c;
    issue_src1 = s1;
    issue_src2 = s2;
    issue_imm = im;
    issue_valid = 1'b1;
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    issue_ctrl = 7'($urandom);
    issue_src1 = RW'($urandom);
    issue_src2 = RW'($urandom);
    issue_imm = IW'($urandom);
    active = 1;
    k = 1;
    while (active) begin
      @(negedge clock);
      if (enable_ex === 1'b1) en_cycles++;
      if (mem_req === 1'b1) req_cycles++;
      if (wb_valid === 1'b1 && wbv_first < 0) begin
        wbv_first = k;
        obs_data = wb_data;
        obs_err = wb_error;
      end
      kill = (k == flush_at);
      flush = kill && !by_reset;
      reset = kill && by_reset;
      if (k >= wb_start) wb_ready = (k >= wb_start + wb_hold);
      else wb_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      #1;
      flush = 1'b0;
      reset = 1'b0;
      if (kill) begin
        active = 0;
        if (by_reset) exp_count = '0;
      end else if (k >= wb_start && wb_ready) begin
        active = 0;
        exp_count = exp_count + 16'd1;
      end else begin
        k++;
      end
      wb_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] c0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_enable_ex", enable_ex, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_instr_count", instr_count, 0);
    checking = 1;

    // ALU op with stubbed result 12
    run_instr(7'h03, 16'd5, 16'd7, 8'h00, 16'd12, 1'b0, -1, 16'h0, 0, -1, 0);
    check("t1_en_cycles", en_cycles, 1);
    check("t1_wb_latency", wbv_first, 3);
    check("t1_wb_data", obs_data, 16'd12);
    check("t1_count", instr_count, 1);

    // load, ack after 4 wait cycles
    run_instr(7'h40, 16'h1111, 16'h2222, 8'h85, 16'h0020, 1'b1, 4, 16'hBEEF, 0, -1, 0);
    check("t2_req_cycles", req_cycles, 5);
    check("t2_wb_data", obs_data, 16'hBEEF);
    check("t2_wb_error", obs_err, 0);

    // store, ack withheld: timeout
    run_instr(7'h20, 16'h0001, 16'h0055, 8'h10, 16'h0030, 1'b0, -1, 16'h0, 0, -1, 0);
    check("t3_req_cycles", req_cycles, 15);
    check("t3_wb_error", obs_err, 1);
    check("t3_wb_data", obs_data, 0);

    // store, ack exactly in the 15th cycle
    run_instr(7'h20, 16'h0001, 16'h0066, 8'h10, 16'h0044, 1'b0, 14, 16'h0, 0, -1, 0);
    check("t3b_req_cycles", req_cycles, 15);
    check("t3b_wb_error", obs_err, 0);
    check("t3b_wb_data", obs_data, 16'h0044);

    // illegal control word
    run_instr(7'h60, 16'h0003, 16'h0004, 8'h00, 16'h0007, 1'b1, 0, 16'h0, 0, -1, 0);
    check("t4_en_cycles", en_cycles, 0);
    check("t4_req_cycles", req_cycles, 0);
    check("t4_wb_latency", wbv_first, 1);
    check("t4_wb_error", obs_err, 1);

    // writeback back-pressure for 10 cycles
    c0 = instr_count;
    run_instr(7'h05, 16'h00AA, 16'h00BB, 8'hFF, 16'h1234, 1'b1, -1, 16'h0, 10, -1, 0);
    check("t5_count", instr_count, c0 + 16'd1);

    // flush in the middle of a memory access, then late acks
    c0 = instr_count;
    run_instr(7'h40, 16'h0001, 16'h0002, 8'h00, 16'h0080, 1'b0, -1, 16'h0, 0, 6, 0);
    repeat (3) @(negedge clock);
    check("t6_count", instr_count, c0);
    check("t6_no_wb", wbv_first, -1);
    check("t6_issue_ready", issue_ready, 1);

    // reset in the middle of a memory access
    run_instr(7'h20, 16'h0001, 16'h0002, 8'h00, 16'h0090, 1'b0, -1, 16'h0, 0, 5, 1);
    @(negedge clock);
    check("t7_count", instr_count, 0);

    // flush together with issue_valid while idle: not accepted
    @(negedge clock);
    issue_ctrl = 7'h03;
    issue_valid = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    check("t8_not_accepted", issue_ready, 1);
    check("t8_no_enable", enable_ex, 0);

    for (int i = 0; i < 40; i++) begin
      int sel;
      int fa;
      logic [6:0] c;
      sel = $urandom_range(0, 9);
      c = {2'b00, 5'($urandom)};
      if (sel < 3) c[6] = 1'b1;
      else if (sel < 6) c[5] = 1'b1;
      else if (sel == 6) c[6:5] = 2'b11;
      fa = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : -1;
      run_instr(c, RW'($urandom), RW'($urandom), IW'($urandom), RW'($urandom),
                1'($urandom_range(0, 1)), $urandom_range(0, 17), RW'($urandom),
                $urandom_range(0, 3), fa, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    @(negedge clock);
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_sequencer.md
Name: ex_sequencer

Overview:
- Single-issue controller that sequences the Execute stage for one instruction at a time.
- Accepts a decoded instruction over a valid/ready handshake and pulses enable_ex for one cycle.
- Captures the ALU result and carry; for memory instructions, runs a data-memory request with wait states and timeout.
- Returns the result on a valid/ready writeback handshake. Sits between decode and the Execute stage / data memory port.

Parameters:
- REG_WD, `REGISTER_WIDTH, operand, result and memory data width.
- IMM_WD, `IMMEDIATE_WIDTH, width of the immediate carried with the instruction.
- MEM_TIMEOUT, 15, max wait cycles for mem_ack before the access is aborted with an error.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort of the in-flight instruction.
- issue_valid  in  1  decoded instruction available.
- issue_ready  out  1  sequencer can accept an instruction.
- issue_ctrl  in  7  control word: [6] mem_read, [5] mem_write, [4:0] ALU op.
- issue_src1, issue_src2  in  REG_WD  operands.
- issue_imm  in  IMM_WD  immediate.
- enable_ex  out  1  one-cycle Execute enable.
- ex_src1, ex_src2  out  REG_WD  operands to Execute.
- ex_imm  out  REG_WD  immediate, sign-extended to REG_WD.
- ex_control  out  7  control word to Execute.
- aluout  in  REG_WD  Execute result, valid the cycle after enable_ex.
- carry  in  1  Execute carry, same timing as aluout.
- mem_req  out  1  data-memory request, held until ack or timeout.
- mem_we  out  1  1 = store.
- mem_addr  out  REG_WD  captured aluout.
- mem_wdata  out  REG_WD  latched src2.
- mem_ack  in  1  memory completion.
- mem_rdata  in  REG_WD  load data, valid with mem_ack.
- wb_valid  out  1  result available.
- wb_ready  in  1  consumer accepts result.
- wb_data  out  REG_WD  result.
- wb_carry  out  1  captured carry.
- wb_error  out  1  illegal control word or memory timeout.
- instr_count  out  16  retired-instruction counter.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs are 0 except issue_ready, which is 1. Internal operand, control, timeout and instruction-counter registers clear.
- FSM states: IDLE, EXEC, CAPT, MEM, WB.
- IDLE:
  - issue_ready=1.
  - When issue_valid is high, latch ctrl, src1, src2 and sign-extended imm.
  - If ctrl[6]&ctrl[5] (illegal): go to WB with wb_error=1 and wb_data=0. enable_ex is never asserted.
  - Otherwise go to EXEC.
- EXEC: enable_ex=1 for exactly one cycle; ex_* drive the latched values, stable from EXEC through CAPT. Next state CAPT.
- CAPT:
  - Register aluout→result and carry→wb_carry.
  - If ctrl[6]|ctrl[5]: go to MEM and clear the timeout counter.
  - Otherwise go to WB.
- MEM:
  - mem_req=1, mem_we=ctrl[5], mem_addr=captured aluout, mem_wdata=src2; all held stable until exit.
  - Counter increments each cycle without ack.
  - On mem_ack: loads set wb_data=mem_rdata; stores set wb_data=address. Go to WB.
  - When the counter reaches MEM_TIMEOUT without ack: wb_error=1, wb_data=0, go to WB.
  - mem_ack in the same cycle the counter hits the limit: ack wins, no error.
  - mem_req deasserts the cycle after exit.
- WB:
  - wb_valid=1; wb_data, wb_carry and wb_error held stable until wb_ready.
  - On wb_ready: instr_count++ (wraps at 2^16-1→0; errored instructions also count). Go to IDLE; wb_* clear to 0.
- Best-case latency, ALU op, issue handshake to wb_valid: 3 cycles (EXEC, CAPT, WB).
- Memory op latency: 3 + wait cycles + 1.
- flush in any non-IDLE state: next cycle IDLE, mem_req/enable_ex/wb_valid low, instr_count unchanged. A late mem_ack after flush is ignored.
- flush with issue_valid in IDLE: the instruction is not accepted.
- reset overrides flush; reset mid-operation behaves as flush and also clears instr_count.

Decomposition:
- Shared package ex_seq_pkg:
  - State enum.
  - Control-bit index constants (CTRL_MEM_RD=6, CTRL_MEM_WR=5, ALU op field [4:0]).
  - Illegal-control check function.
  - MEM_TIMEOUT default.
- Widths come from data_defs.
- One sub-module, ex_seq_mem_timer: loadable wait counter with clear/enable inputs and a timeout flag.

Test Plan:
- Reset then ALU op, ctrl=7'h03, src1=5, src2=7, wb_ready=1 → enable_ex high for exactly 1 cycle; wb_valid on the 3rd cycle after the handshake with wb_data equal to the stubbed aluout=12; instr_count=1.
- Load, ctrl=7'h40, aluout=0x20, mem_ack after 4 wait cycles, mem_rdata=0xBEEF → mem_req high for 5 cycles with mem_addr=0x20 and mem_we=0; wb_data=0xBEEF; wb_error=0.
- Store, ctrl=7'h20, src2=0x55, mem_ack withheld → mem_req held for MEM_TIMEOUT=15 cycles with mem_wdata=0x55; then wb_error=1, wb_data=0. Separately, ack on exactly the 15th cycle → wb_error=0.
- Illegal ctrl=7'h60 → enable_ex never asserts, mem_req never asserts; wb_valid on the cycle after accept with wb_error=1.
- wb_ready held low for 10 cycles → wb_* stable and issue_ready=0 throughout; accepted the cycle wb_ready rises.
- flush during MEM, then a late mem_ack → next cycle IDLE, issue_ready=1, no wb_valid, instr_count unchanged. Repeat with reset: instr_count=0.
